// File: rtl/rf_ctrl_pkg.sv
// Shared types and defaults for the register-bank writeback scheduler.
package rf_ctrl_pkg;

   localparam int RF_DIR_WIDTH  = 5;
   localparam int RF_DATA_WIDTH = 32;

   typedef enum logic {
      WB_ALU = 1'b0,
      WB_LSU = 1'b1
   } wb_src_e;

   localparam logic [RF_DIR_WIDTH-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for outstanding destination registers, with hazard lookup
// that ignores a register whose writeback is committing this cycle.
module rf_scoreboard #(
   parameter int DIR_WIDTH = rf_ctrl_pkg::RF_DIR_WIDTH,
   parameter int NUM_REGS  = 2**DIR_WIDTH
) (
   input  logic                 clk,
   input  logic                 arst_n,
   input  logic                 set_en,
   input  logic [DIR_WIDTH-1:0] set_dir,
   input  logic                 clr_en,
   input  logic [DIR_WIDTH-1:0] clr_dir,
   input  logic [DIR_WIDTH-1:0] rs1,
   input  logic [DIR_WIDTH-1:0] rs2,
   input  logic [DIR_WIDTH-1:0] rd,
   output logic                 hazard,
   output logic [NUM_REGS-1:0]  busy_vec
);

   logic [NUM_REGS-1:0] busy_reg;
   logic [NUM_REGS-1:0] busy_next;
   logic [NUM_REGS-1:0] commit_mask;
   logic [NUM_REGS-1:0] eff_busy;

   assign busy_next[0]   = 1'b0;
   assign commit_mask[0] = clr_en && (clr_dir == '0);

   genvar gi;
   generate
      for (gi = 1; gi < NUM_REGS; gi++) begin : g_bit
         assign commit_mask[gi] = clr_en && (clr_dir == DIR_WIDTH'(gi));
         // A fresh producer outranks the retiring one on the same edge.
         assign busy_next[gi] = (set_en && (set_dir == DIR_WIDTH'(gi))) ? 1'b1 :
                                commit_mask[gi]                         ? 1'b0 :
                                                                          busy_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         busy_reg <= '0;
      end else begin
         busy_reg <= busy_next;
      end
   end

   // The bank forwards the committing value, so that register no longer blocks.
   assign eff_busy = busy_reg & ~commit_mask;
   assign hazard   = eff_busy[rs1] | eff_busy[rs2] | eff_busy[rd];
   assign busy_vec = busy_reg;

endmodule

// File: rtl/bank_reg_wb_sched.sv
// Round-robin writeback arbiter with a registered write stage and an issue
// scoreboard in front of the 2R/1W register bank.
module bank_reg_wb_sched #(
   parameter int DIR_WIDTH  = rf_ctrl_pkg::RF_DIR_WIDTH,
   parameter int DATA_WIDTH = rf_ctrl_pkg::RF_DATA_WIDTH,
   parameter int NUM_REGS   = 2**DIR_WIDTH
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  issue_valid,
   input  logic [DIR_WIDTH-1:0]  issue_rd,
   input  logic [DIR_WIDTH-1:0]  issue_rs1,
   input  logic [DIR_WIDTH-1:0]  issue_rs2,
   output logic                  issue_stall,
   input  logic                  alu_valid,
   input  logic [DIR_WIDTH-1:0]  alu_dir,
   input  logic [DATA_WIDTH-1:0] alu_data,
   output logic                  alu_ready,
   input  logic                  lsu_valid,
   input  logic [DIR_WIDTH-1:0]  lsu_dir,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   output logic                  lsu_ready,
   output logic                  rf_write_en,
   output logic [DIR_WIDTH-1:0]  rf_write_dir,
   output logic [DATA_WIDTH-1:0] rf_write_data,
   output logic [NUM_REGS-1:0]   busy_vec
);

   import rf_ctrl_pkg::*;

   wb_src_e               prio_reg;
   wb_src_e               prio_next;
   logic                  grant_alu;
   logic                  grant_lsu;
   logic                  wr_en_reg;
   logic                  wr_en_next;
   logic [DIR_WIDTH-1:0]  wr_dir_reg;
   logic [DIR_WIDTH-1:0]  wr_dir_next;
   logic [DATA_WIDTH-1:0] wr_data_reg;
   logic [DATA_WIDTH-1:0] wr_data_next;
   logic                  hazard;
   logic                  issue_accept;

   always_comb begin
      grant_alu = alu_valid && (!lsu_valid || (prio_reg == WB_ALU));
      grant_lsu = lsu_valid && (!alu_valid || (prio_reg == WB_LSU));
   end

   // Pointer moves on every grant, contended or not.
   always_comb begin
      prio_next    = prio_reg;
      wr_en_next   = 1'b0;
      wr_dir_next  = wr_dir_reg;
      wr_data_next = wr_data_reg;
      if (grant_alu) begin
         prio_next    = WB_LSU;
         wr_en_next   = (alu_dir != DIR_WIDTH'(REG_ZERO));
         wr_dir_next  = alu_dir;
         wr_data_next = alu_data;
      end else if (grant_lsu) begin
         prio_next    = WB_ALU;
         wr_en_next   = (lsu_dir != DIR_WIDTH'(REG_ZERO));
         wr_dir_next  = lsu_dir;
         wr_data_next = lsu_data;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         prio_reg    <= WB_ALU;
         wr_en_reg   <= 1'b0;
         wr_dir_reg  <= '0;
         wr_data_reg <= '0;
      end else begin
         prio_reg    <= prio_next;
         wr_en_reg   <= wr_en_next;
         wr_dir_reg  <= wr_dir_next;
         wr_data_reg <= wr_data_next;
      end
   end

   assign issue_stall  = issue_valid && hazard;
   assign issue_accept = issue_valid && !hazard && (issue_rd != DIR_WIDTH'(REG_ZERO));

   rf_scoreboard #(
      .DIR_WIDTH (DIR_WIDTH),
      .NUM_REGS  (NUM_REGS)
   ) u_scoreboard (
      .clk      (clk),
      .arst_n   (arst_n),
      .set_en   (issue_accept),
      .set_dir  (issue_rd),
      .clr_en   (wr_en_reg),
      .clr_dir  (wr_dir_reg),
      .rs1      (issue_rs1),
      .rs2      (issue_rs2),
      .rd       (issue_rd),
      .hazard   (hazard),
      .busy_vec (busy_vec)
   );

   assign alu_ready     = grant_alu;
   assign lsu_ready     = grant_lsu;
   assign rf_write_en   = wr_en_reg;
   assign rf_write_dir  = wr_dir_reg;
   assign rf_write_data = wr_data_reg;

endmodule

// File: doc/bank_reg_wb_sched.md
Name: bank_reg_wb_sched

Overview:
Scheduler and controller in front of the 32x32 register bank (2 read ports, 1 write port, write-through on address match).
- Arbitrates the single write port between two writeback requesters (ALU, LSU) with round-robin priority and a one-cycle registered write stage.
- Keeps a busy scoreboard of destination registers that have been issued but not yet written back, and stalls issue on RAW/WAW hazards.
- Sits between the control unit's issue stage, the execution units and the bank's write_en/write_dir/write_data inputs.

Parameters:
DIR_WIDTH, 5, register address width
DATA_WIDTH, 32, register data width
NUM_REGS, 2**DIR_WIDTH, number of architectural registers (x0 hardwired zero)

Ports:
clk  in  1  clock, rising-edge
arst_n  in  1  asynchronous active-low reset
issue_valid  in  1  control unit presents an instruction for issue
issue_rd  in  DIR_WIDTH  destination register of issuing instruction (0 = no write)
issue_rs1  in  DIR_WIDTH  source register 1
issue_rs2  in  DIR_WIDTH  source register 2
issue_stall  out  1  issue blocked by hazard; instruction is not accepted
alu_valid  in  1  ALU writeback request
alu_dir  in  DIR_WIDTH  ALU writeback address
alu_data  in  DATA_WIDTH  ALU writeback data
alu_ready  out  1  ALU request granted this cycle
lsu_valid  in  1  LSU writeback request
lsu_dir  in  DIR_WIDTH  LSU writeback address
lsu_data  in  DATA_WIDTH  LSU writeback data
lsu_ready  out  1  LSU request granted this cycle
rf_write_en  out  1  to bank write_en
rf_write_dir  out  DIR_WIDTH  to bank write_dir
rf_write_data  out  DATA_WIDTH  to bank write_data
busy_vec  out  NUM_REGS  scoreboard state; bit 0 is always 0

Behaviour:
- Reset (arst_n low, asynchronous):
  - rf_write_en, rf_write_dir, rf_write_data and busy_vec go to 0.
  - Priority pointer goes to ALU.
  - A pending registered write is discarded.
- Arbitration:
  - Combinational; at most one grant per cycle; the transfer happens when valid and ready are both high at a rising edge.
  - Only one valid: that requester is granted.
  - Both valid: the requester named by the priority pointer is granted.
  - The pointer flips to the other requester after every grant, whether or not there was contention.
  - Ready depends combinationally on both valids; requesters must hold valid, dir and data until ready.
- Write stage:
  - A grant at edge N loads the output register, and rf_write_en is high during the cycle following edge N.
  - Latency is exactly 1 cycle. There is no backpressure from the bank.
  - A granted request with dir=0 is accepted (ready=1), but rf_write_en stays 0.
  - With no grant, rf_write_en=0 and dir/data hold their last values.
- Scoreboard:
  - busy[rd] is set at the edge where issue_valid=1, issue_stall=0 and issue_rd!=0.
  - busy[dir] is cleared at the edge ending a cycle in which rf_write_en=1 for that dir.
  - Set and clear of the same register at the same edge: set wins, because a new producer is outstanding.
  - A writeback to a non-busy register still commits, and busy stays 0.
- Stall:
  - issue_stall = issue_valid & (eff_busy[rs1] | eff_busy[rs2] | eff_busy[rd]).
  - eff_busy = busy_vec & ~commit_mask, where commit_mask is the one-hot of rf_write_dir when rf_write_en=1.
  - A register committing this cycle does not stall its reader, because the bank forwards write_data to matching read addresses.
  - Address 0 never stalls.
  - issue_stall is 0 whenever issue_valid=0.

Decomposition:
- Package rf_ctrl_pkg:
  - DIR_WIDTH and DATA_WIDTH defaults.
  - Enum wb_src_e {WB_ALU, WB_LSU} for the priority pointer.
  - Constant REG_ZERO = '0.
- Sub-module rf_scoreboard:
  - Holds the busy vector: set/clear ports, commit mask, and hazard lookup for rs1/rs2/rd.
- Arbitration and the write stage stay in the top module.

Test Plan:
1. Reset mid-write: ALU grant (dir=5, data=0xA5) at edge N, then arst_n low before edge N+1 -> rf_write_en=0 immediately; busy_vec=0; after release, a single LSU request is granted first.
2. Contention: ALU (dir=3, data=0x11) and LSU (dir=4, data=0x22) both held valid from reset -> ALU written cycle 1, LSU cycle 2, alu_ready/lsu_ready each high for exactly 1 cycle.
3. RAW stall: issue rd=7, then issue rs1=7 the next cycle -> issue_stall=1 until the cycle rf_write_en=1 with dir=7; stall=0 in that same cycle; busy_vec[7]=0 afterwards.
4. Set/clear collision: busy[9]=1, writeback of dir=9 in flight, new issue rd=9 accepted in the commit cycle -> busy_vec[9] remains 1.
5. x0 handling: issue rd=0, rs1=0, and LSU writeback dir=0 data=0xFFFF_FFFF -> no stall, lsu_ready=1, rf_write_en stays 0, busy_vec=0.
6. Round-robin fairness: both requesters continuously valid for 8 cycles -> grants alternate ALU, LSU, ALU, ...; 4 writes each; no two consecutive grants to the same source.
